// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, fills a small fetch queue from IMEM, and hands words to decode.
// Optional FETCH_PERF_EN adds saturating fetch/stall performance counters.
module imem_fetch_ctrl #(
    parameter int                ADDR_W     = 32,
    parameter int                IMEM_DEPTH = 128,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                QDEPTH     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halt
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int                PTR_W    = $clog2(QDEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(IMEM_DEPTH);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(QDEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   fetch_pc;
    logic [PTR_W-1:0]    head_ptr, tail_ptr;
    logic [CNT_W-1:0]    count;
    logic [ADDR_W-1:0]   q_pc    [QDEPTH];
    logic [31:0]         q_instr [QDEPTH];

    logic in_range, q_full, pop, push;

    assign in_range = fetch_pc < DEPTH_A;
    assign q_full   = count == FULL_CNT;
    assign pop      = if_valid && if_ready && !redirect_valid;
    assign push     = (state == RUN) && fetch_en && in_range && (!q_full || pop) && !redirect_valid;

    always_comb begin
        state_nxt = state;
        halt      = 1'b0;
        unique case (state)
            IDLE: state_nxt = RUN;
            RUN: begin
                if (!in_range && count == '0)
                    state_nxt = HALT;
            end
            HALT: halt = 1'b1;
            default: state_nxt = IDLE;
        endcase
        if (redirect_valid)
            state_nxt = RUN;
    end

    // control: state, PC, queue pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            state <= state_nxt;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                head_ptr <= '0;
                tail_ptr <= '0;
                count    <= '0;
            end else begin
                if (push) begin
                    fetch_pc <= fetch_pc + 1'b1;
                    tail_ptr <= tail_ptr + 1'b1;
                end
                if (pop)
                    head_ptr <= head_ptr + 1'b1;
                unique case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // queue storage: data only, validity is tracked by count
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail_ptr]    <= fetch_pc;
            q_instr[tail_ptr] <= imem_instr;
        end
    end

    assign imem_addr = fetch_pc;
    assign if_valid  = count != '0;
    assign if_pc     = if_valid ? q_pc[head_ptr]    : '0;
    assign if_instr  = if_valid ? q_instr[head_ptr] : '0;

`ifdef FETCH_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    logic stall;
    assign stall = (state == RUN) && fetch_en && in_range && q_full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (push)
                perf_fetch_cnt <= sat_inc(perf_fetch_cnt);
            if (stall)
                perf_stall_cnt <= sat_inc(perf_stall_cnt);
        end
    end
`endif

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the word-addressed, combinational-read instruction memory (128 x 32) of the 32-bit MIPS core.
- Owns the fetch PC, drives the IMEM address, and captures each returned word into a small fetch queue.
- Presents queued words to decode over a valid/ready handshake.
- Handles branch redirect (flush) and halts cleanly when the PC leaves the populated IMEM range.

Parameters:
- ADDR_W, 32, width of PC / IMEM address.
- IMEM_DEPTH, 128, number of IMEM words; a PC >= IMEM_DEPTH is out of range.
- RESET_PC, 0, fetch PC after reset.
- QDEPTH, 2, fetch-queue entries; power of two, >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- fetch_en  in  1  permits new fetches; the queue keeps draining when low.
- imem_addr  out  ADDR_W  word index to IMEM; equals fetch_pc.
- imem_instr  in  32  IMEM read data, combinational from imem_addr.
- if_valid  out  1  queue head valid.
- if_ready  in  1  decode accepts the head.
- if_instr  out  32  head instruction.
- if_pc  out  ADDR_W  head instruction word address.
- redirect_valid  in  1  branch/jump taken; one-cycle pulse.
- redirect_pc  in  ADDR_W  target word address.
- halt  out  1  fetch stopped (PC out of range, queue drained).

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC; queue count=0; state=IDLE.
  - Outputs: imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, halt=0.
  - Reset mid-operation discards all queue contents immediately.
- States: IDLE, RUN, HALT (2-bit encoded).
  - IDLE: no fetch; unconditionally -> RUN at the next edge.
  - RUN: normal fetch.
    - -> HALT when fetch_pc >= IMEM_DEPTH and count==0 at the edge.
  - HALT: halt=1; no fetch; imem_addr holds.
    - Leaves only via redirect, -> RUN.
- PC addressing:
  - PC is a word index; sequential next PC = fetch_pc+1 (not +4).
  - Increment is modulo 2^ADDR_W; the range check stops fetch before wrap matters.
- Push (each edge): state==RUN && fetch_en && fetch_pc<IMEM_DEPTH && (count<QDEPTH || pop) && !redirect_valid.
  - On push: entry {fetch_pc, imem_instr} written at tail; fetch_pc<=fetch_pc+1.
- Pop: if_valid && if_ready && !redirect_valid; head advances.
  - Simultaneous push+pop on a full queue is legal; count is unchanged.
- Outputs: if_valid=(count!=0); if_instr/if_pc driven from the head register (no combinational path from imem_instr).
- Latency and throughput:
  - First if_valid rises after the 2nd rising edge following rst_n deassertion.
  - Throughput is 1 instruction/cycle with if_ready held high.
  - Fetch-to-head latency is 1 cycle when the queue is empty.
- Redirect (highest priority, any state incl. IDLE/HALT):
  - At the edge: count<=0, fetch_pc<=redirect_pc, no push, no pop, state<=RUN.
  - if_valid=0 the cycle after.
  - The first redirected word is valid the following cycle (1 bubble).
- Redirect to an out-of-range PC: RUN with count=0 -> HALT at the next edge.
- fetch_en low: fetch_pc frozen; queued entries still drain; halt is not asserted.
- Queue pointers: log2(QDEPTH) bits, wrap naturally; count is log2(QDEPTH)+1 bits.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds two outputs, both reset to 0 by rst_n and saturating at all-ones:
  - perf_fetch_cnt out 32: counts pushes.
  - perf_stall_cnt out 32: counts cycles with state==RUN, fetch_en=1, fetch_pc in range, and the queue full with no pop.
- When undefined, neither port nor the counter logic exists.
- Core behaviour is identical either way.

Test Plan:
- Reset release, if_ready=1, fetch_en=1, IMEM[0..3] loaded:
  - if_valid rises after 2nd edge with if_pc=0, if_instr=IMEM[0].
  - Then if_pc=1,2,3 on consecutive cycles.
- if_ready=0 for 5 cycles from the start:
  - Queue fills with PC 0,1; imem_addr holds at 2.
  - Releasing if_ready delivers 0,1,2 back-to-back with no loss or duplicate.
- Redirect pulse redirect_pc=15 while the queue holds PC 8,9:
  - Next cycle if_valid=0.
  - Following cycle if_pc=15, if_instr=IMEM[15]; PC 8,9 never accepted.
- Run sequentially to PC 127 with if_ready=1:
  - if_pc=127 is delivered, then halt=1 and imem_addr=128 is held.
  - Redirect to 0 clears halt and restarts at PC 0.
- Assert rst_n=0 mid-stream with the queue full:
  - if_valid=0, halt=0, imem_addr=0 immediately, without waiting for a clock edge.
- With FETCH_PERF_EN: 10 fetches then 4 full-queue stall cycles -> perf_fetch_cnt=10, perf_stall_cnt=4.
